float_div_seq: RTL and testbench

Sequential half-precision (1/5/10) floating-point divider that undoes `float_mult`: quotient = dividend / divisor. It sits beside the multiplier in the CNN datapath for normalisation and scaling stages. The number format, zero handling, truncation and out-of-range-to-zero rules are identical to the multiplier's. It uses a 12-iteration restoring mantissa divider with valid/ready handshakes on both sides.

---
 rtl/fp16_pkg.sv | 18 +
 rtl/fp16_pack.sv | 32 +++
 rtl/float_div_seq.sv | 113 +++++++++++
 tb/tb_float_div_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision (1/5/10) arithmetic blocks.
package fp16_pkg;

    localparam int FP16_BIAS = 15;
    localparam int EXP_W     = 5;
    localparam int MANT_W    = 10;
    localparam int FRAC_W    = 11;
    localparam int Q_W       = FRAC_W + 1;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_DONE
    } div_state_t;

endpackage

// File: rtl/fp16_pack.sv
// Normalises a 12-bit raw quotient/product with leading bit at [11] or [10],
// range-checks the biased exponent and packs the FP16 word (out of range -> zero).
module fp16_pack
    import fp16_pkg::*;
(
    input  logic                  i_sign,
    input  logic signed [6:0]     i_exp,
    input  logic        [Q_W-1:0] i_frac,
    output logic        [15:0]    o_word
);

    logic signed [6:0]        w_exp;
    logic        [MANT_W-1:0] w_mant;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_exp  = i_exp;
        w_mant = i_frac[MANT_W-1:0];
        if (i_frac[Q_W-1]) begin
            w_mant = i_frac[Q_W-2:1];
        end else begin
            w_exp = i_exp - 7'sd1;
        end

        if (w_exp < 7'sd0 || w_exp > 7'sd31) begin
            o_word = FP16_ZERO;
        end else begin
            o_word = {i_sign, w_exp[EXP_W-1:0], w_mant};
        end
    end

endmodule

// File: rtl/float_div_seq.sv
// Sequential FP16 divider: 12-iteration restoring mantissa division with
// valid/ready handshakes; truncating, zero-flushing, same rules as float_mult.
module float_div_seq
    import fp16_pkg::*;
#(
    parameter int BIAS = FP16_BIAS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic        div_by_zero
);

    localparam int R_W = Q_W - 1;

    div_state_t          r_state;
    div_state_t          w_state_next;
    logic [Q_W-1:0]      r_rem;
    logic [Q_W-1:0]      r_d;
    logic [R_W-1:0]      r_q;
    logic [3:0]          r_cnt;
    logic signed [6:0]   r_exp;
    logic                r_sign;
    logic                r_zero;
    logic                r_byzero;
    logic [15:0]         r_quotient;
    logic                r_dbz;

    logic                w_accept;
    logic                w_ge;
    logic                w_last;
    logic [R_W-1:0]      w_rem_sub;
    logic [Q_W-1:0]      w_q_next;
    logic signed [6:0]   w_exp_init;
    logic [15:0]         w_packed;

    assign w_accept   = in_valid && in_ready;
    assign w_ge       = (r_rem >= r_d);
    assign w_rem_sub  = w_ge ? R_W'(r_rem - r_d) : r_rem[R_W-1:0];
    assign w_q_next   = {r_q, w_ge};
    assign w_last     = (r_cnt == 4'd11);
    assign w_exp_init = $signed({2'b00, floatA[14:10]}) - $signed({2'b00, floatB[14:10]}) + 7'(BIAS);

    fp16_pack u_pack (
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_frac (w_q_next),
        .o_word (w_packed)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)  w_state_next = ST_DIVIDE;
            ST_DIVIDE: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:   if (out_ready) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem      <= '0;
            r_d        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_byzero   <= 1'b0;
            r_quotient <= FP16_ZERO;
            r_dbz      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_sign   <= floatA[15] ^ floatB[15];
                r_exp    <= w_exp_init;
                r_rem    <= {1'b1, floatA[MANT_W-1:0]};
                r_d      <= {1'b1, floatB[MANT_W-1:0]};
                r_q      <= '0;
                r_zero   <= (floatA == FP16_ZERO) || (floatB == FP16_ZERO);
                r_byzero <= (floatB == FP16_ZERO);
                // Zero operands skip to the final iteration: result is ready one cycle after accept.
                r_cnt    <= ((floatA == FP16_ZERO) || (floatB == FP16_ZERO)) ? 4'd11 : 4'd0;
            end else if (r_state == ST_DIVIDE) begin
                r_rem <= {w_rem_sub, 1'b0};
                r_q   <= w_q_next[R_W-1:0];
                r_cnt <= r_cnt + 4'd1;
                if (w_last) begin
                    r_quotient <= r_zero ? FP16_ZERO : w_packed;
                    r_dbz      <= r_byzero;
                end
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !reset;
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_float_div_seq.sv
// Directed bench for float_div_seq: hand-computed quotients, latency,
// back-pressure and mid-division reset.
module tb_float_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] floatA = 16'h0000;
    logic [15:0] floatB = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    float_div_seq #(.BIAS(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .floatA      (floatA),
        .floatB      (floatB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        floatA   = a;
        floatB   = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        floatA   = 16'hDEAD;
        floatB   = 16'hBEEF;
        check({tag, "_ready_busy"}, in_ready, 0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_q, input logic exp_dbz, input int exp_lat);
        int lat;
        start(tag, a, b);
        wait_valid(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        handshake(tag);
    endtask

    initial begin
        int lat;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("rst_release_ready", in_ready, 1);
        @(posedge clk); #1;

        do_div("3_div_1p5",  16'h4200, 16'h3E00, 16'h4000, 1'b0, 12);
        do_div("m3_div_1p5", 16'hC200, 16'h3E00, 16'hC000, 1'b0, 12);
        do_div("1_div_3",    16'h3C00, 16'h4200, 16'h3555, 1'b0, 12);
        do_div("5_div_2",    16'h4500, 16'h4000, 16'h4100, 1'b0, 12);
        do_div("1_div_0",    16'h3C00, 16'h0000, 16'h0000, 1'b1, 1);
        do_div("0_div_3",    16'h0000, 16'h4200, 16'h0000, 1'b0, 1);
        do_div("underflow",  16'h0400, 16'h7800, 16'h0000, 1'b0, 12);
        do_div("overflow",   16'h7800, 16'h0400, 16'h0000, 1'b0, 12);

        // Back-pressure: result must hold while the consumer stalls.
        start("bp", 16'h3C00, 16'h4200);
        wait_valid(lat);
        check("bp_latency", lat, 12);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_quotient", quotient, 16'h3555);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        handshake("bp");
        do_div("b2b_1_div_0", 16'h3C00, 16'h0000, 16'h0000, 1'b1, 1);
        do_div("b2b_5_div_2", 16'h4500, 16'h4000, 16'h4100, 1'b0, 12);

        // Reset in the middle of a division (iteration 6).
        start("mid_rst", 16'h4200, 16'h3E00);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_busy", out_valid, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 check("mid_rst_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1 check("mid_rst_no_stale_done", out_valid, 0);
        do_div("post_rst_3_div_1p5", 16'h4200, 16'h3E00, 16'h4000, 1'b0, 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
